// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: opcodes and FSM states.
package mdu_pkg;
  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_FIX  = 2'd2;
  localparam state_t S_DONE = 2'd3;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
endpackage

// File: rtl/mdu_abs.sv
// Two's-complement conditional negate; used both for operand magnitudes and result sign fix-up.
module mdu_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);
  assign y = neg ? ((~x) + WIDTH'(1)) : x;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div, sgn_a, sgn_b, dz;
  logic [WIDTH-1:0] acc, q, mb;

  logic             signed_op, idle_or_done, accept;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign signed_op    = SIGNED_EN && !op[0];
  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign accept       = idle_or_done && start && !flush;
  assign busy         = (state == S_CALC) || (state == S_FIX);
  assign done         = (state == S_DONE);
  assign stall_req    = rst & (busy | (start & idle_or_done & ~flush));

  mdu_abs #(.WIDTH(WIDTH)) u_abs_a (.x(a), .neg(signed_op & a[WIDTH-1]), .y(mag_a));
  mdu_abs #(.WIDTH(WIDTH)) u_abs_b (.x(b), .neg(signed_op & b[WIDTH-1]), .y(mag_b));

  // acc holds the running upper product / partial remainder; q the lower product / quotient
  logic [WIDTH:0] m_sum, d_sh, d_diff;
  always_comb begin
    m_sum  = {1'b0, acc} + (q[0] ? {1'b0, mb} : '0);
    d_sh   = {acc, q[WIDTH-1]};
    d_diff = d_sh - {1'b0, mb};
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

  mdu_abs #(.WIDTH(2*WIDTH)) u_abs_p (.x({acc, q}), .neg(sgn_a ^ sgn_b), .y(prod));
  mdu_abs #(.WIDTH(WIDTH))   u_abs_q (.x(q),        .neg(sgn_a ^ sgn_b), .y(quo));
  mdu_abs #(.WIDTH(WIDTH))   u_abs_r (.x(acc),      .neg(sgn_a),         .y(rem));

  // Divide by zero: the remainder path already restores a, only the quotient is forced
  assign res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
  assign res_lo = is_div ? (dz ? '1 : quo) : prod[WIDTH-1:0];

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      dz     <= 1'b0;
      acc    <= '0;
      q      <= '0;
      mb     <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (flush) state <= S_IDLE;
      else begin
        case (state)
          S_IDLE, S_DONE: state <= start ? S_CALC : S_IDLE;
          S_CALC:         if (cnt == CW'(WIDTH-1)) state <= S_FIX;
          default:        state <= S_DONE;
        endcase
      end

      if (accept) begin
        is_div <= op[1];
        sgn_a  <= signed_op & a[WIDTH-1];
        sgn_b  <= signed_op & b[WIDTH-1];
        dz     <= (b == '0);
        mb     <= mag_b;
        acc    <= '0;
        q      <= mag_a;
        cnt    <= '0;
      end else if (state == S_CALC) begin
        cnt <= cnt + CW'(1);
        if (is_div) begin
          acc <= d_diff[WIDTH] ? d_sh[WIDTH-1:0] : d_diff[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], ~d_diff[WIDTH]};
        end else begin
          acc <= m_sum[WIDTH:1];
          q   <= {m_sum[0], q[WIDTH-1:1]};
        end
      end

      if (state == S_FIX) begin
        if (!flush) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end else if (idle_or_done) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit at WIDTH=32: results, latency, flush, reset, HI/LO writes.
module tb_mul_div_unit;
  import mdu_pkg::*;
  localparam int W = 32;

  logic         clka = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
  logic         hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         busy, stall_req, done;
  logic [W-1:0] hi, lo;

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [2*W-1:0] exp_q[$];
  int             cyc_q[$];
  logic [2*W-1:0] e;
  int             c;

  mul_div_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clka(clka), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .stall_req(stall_req),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, qq, rr;
    logic [63:0] r;
    sx = 64'($signed(x));
    sy = 64'($signed(y));
    case (o)
      OP_MULT:  r = sx * sy;
      OP_MULTU: r = {32'd0, x} * {32'd0, y};
      OP_DIV: begin
        if (y == 32'd0) r = {x, 32'hFFFFFFFF};
        else begin
          qq = sx / sy;
          rr = sx % sy;
          r  = {rr[31:0], qq[31:0]};
        end
      end
      default: r = (y == 32'd0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
    endcase
    return r;
  endfunction

  always @(negedge clka) begin
    if (rst && done) begin
      if (exp_q.size() == 0) chk("unexp_done", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        chk("res_hi", 64'(hi), 64'(e[63:32]));
        chk("res_lo", 64'(lo), 64'(e[31:0]));
        chk("latency", 64'(cyc), 64'(c));
      end
    end
  end

  // Start is accepted at the edge after the drive; done is visible 33 edges later
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clka); #1;
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(model(o, x, y));
    cyc_q.push_back(cyc + 34);
    #1 chk("stall_start", 64'(stall_req), 64'd1);
    @(posedge clka); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    chk("busy_calc", 64'(busy), 64'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clka);
    if (exp_q.size() != 0) begin
      chk("timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      cyc_q.delete();
    end
    @(posedge clka); #1;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    start = 1'b1;
    repeat (3) @(posedge clka);
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    start = 1'b0;
    rst = 1'b1;
    @(posedge clka); #1;
    chk("idle_busy", 64'(busy), 64'd0);

    issue(OP_MULT,  32'hFFFFFFFF, 32'd3);          wait_done();
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd3);          wait_done();
    issue(OP_DIV,   32'hFFFFFFF9, 32'd2);          wait_done();
    issue(OP_DIVU,  32'd7,        32'd0);          wait_done();
    issue(OP_DIV,   32'hFFFFFFF9, 32'd0);          wait_done();
    issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF);   wait_done();
    issue(OP_MULT,  32'h80000000, 32'h80000000);   wait_done();

    for (int i = 0; i < 16; i++) begin
      ro = 2'(i);
      ra = $urandom;
      rb = (i % 3 == 0) ? $urandom_range(1, 15) : $urandom;
      if (i % 5 == 1) rb = -rb;
      issue(ro, ra, rb);
      wait_done();
    end

    // Back-to-back with HI/LO write behaviour around it
    lo_we = 1'b1; wdata = 32'h55;
    @(posedge clka); #1;
    lo_we = 1'b0;
    chk("lo_we_idle", 64'(lo), 64'h55);
    issue(OP_MULTU, 32'd2, 32'd3);
    lo_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clka); #1;
    lo_we = 1'b0;
    chk("lo_we_calc", 64'(lo), 64'h55);
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clka); #1;
    end
    start = 1'b1; op = OP_MULTU; a = 32'd4; b = 32'd5;
    exp_q.push_back(model(OP_MULTU, 32'd4, 32'd5));
    cyc_q.push_back(cyc + 34);
    @(posedge clka); #1;
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done();
    chk("b2b_lo", 64'(lo), 64'd20);
    lo_we = 1'b1; wdata = 32'h1234;
    @(posedge clka); #1;
    lo_we = 1'b0;
    chk("lo_we_idle2", 64'(lo), 64'h1234);

    // Flush mid-CALC
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11;
    @(posedge clka); #1;
    lo_we = 1'b1; hi_we = 1'b0; wdata = 32'h22;
    @(posedge clka); #1;
    lo_we = 1'b0;
    start = 1'b1; op = OP_MULT; a = 32'd7; b = 32'd9;
    @(posedge clka); #1;
    start = 1'b0;
    repeat (9) @(posedge clka);
    #1 flush = 1'b1;
    @(posedge clka); #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_hi", 64'(hi), 64'h11);
    chk("flush_lo", 64'(lo), 64'h22);
    repeat (40) @(posedge clka);
    #1;
    chk("flush_lo_late", 64'(lo), 64'h22);
    start = 1'b1; flush = 1'b1;
    #1 chk("flush_start_stall", 64'(stall_req), 64'd0);
    @(posedge clka); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_wins", 64'(busy), 64'd0);

    // Asynchronous reset mid-CALC
    start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
    @(posedge clka); #1;
    start = 1'b0;
    repeat (5) @(posedge clka);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    start = 1'b1;
    #1 chk("arst_stall", 64'(stall_req), 64'd0);
    @(posedge clka); #1;
    start = 1'b0;
    rst = 1'b1;
    issue(OP_MULTU, 32'd5, 32'd5);
    wait_done();
    chk("post_rst_lo", 64'(lo), 64'd25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and HI/LO width, even, >= 8.
REQ-002 SHALL have parameter SIGNED_EN, default 1: 1 enables MULT/DIV; 0 executes them as MULTU/DIVU.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clka input 1 (rising-edge clock); rst input 1 (asynchronous, active-low reset).
REQ-004 SHALL have port start, input, width 1: request a new operation.
REQ-005 SHALL have port op, input, width 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports a and b, input, width WIDTH: multiplicand/dividend and multiplier/divisor.
REQ-007 SHALL have port flush, input, width 1: cancel any operation in progress.
REQ-008 SHALL have ports hi_we and lo_we, input, width 1, plus port wdata, input, width WIDTH: MTHI/MTLO write.
REQ-009 SHALL have port busy, output, width 1: operation in progress.
REQ-010 SHALL have port stall_req, output, width 1: pipeline hold request.
REQ-011 SHALL have port done, output, width 1: one-cycle completion pulse.
REQ-012 SHALL have ports hi and lo, output, width WIDTH: architectural HI/LO registers.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-014 SHALL accept start only in IDLE or DONE with flush=0; at that edge it latches op, the operand magnitudes and the sign flags, clears the iteration counter, and goes to CALC.
REQ-015 In CALC, SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring subtract for divide; after exactly WIDTH steps it goes to FIX.
REQ-016 In FIX, SHALL apply sign correction and write the 2*WIDTH result into hi/lo at the FIX->DONE edge.
REQ-017 In DONE, SHALL hold done=1 for exactly one cycle, then go to IDLE, or to CALC if a new start is accepted.
REQ-018 Latency: with start sampled at edge t0, done SHALL be high between edges t0+WIDTH+1 and t0+WIDTH+2.
REQ-019 busy SHALL be 1 in CALC and FIX, else 0; stall_req SHALL equal busy OR (start AND state is IDLE or DONE AND flush=0), combinationally.
REQ-020 Multiply SHALL give hi = upper WIDTH bits and lo = lower WIDTH bits of the product; signed ops negate the product when the operand signs differ.
REQ-021 Divide SHALL give lo = quotient truncated toward zero and hi = remainder; the remainder takes the sign of the dividend.
REQ-022 Divide by zero (any signedness) SHALL give lo = all ones and hi = a, with normal latency.
REQ-023 Signed most-negative / -1 SHALL give lo = most-negative value and hi = 0, with no exception.
REQ-024 flush=1 SHALL force IDLE at the next edge from any state; done is not asserted, hi/lo keep their prior value, and flush wins over a simultaneous start.
REQ-025 hi_we/lo_we SHALL write wdata into hi/lo only in IDLE or DONE; they are ignored in CALC/FIX.
REQ-026 A write and an accepted start at the same edge SHALL both take effect; the later result overwrites it.
REQ-027 Operands SHALL be sampled only at acceptance; changes on a/b/op during CALC/FIX SHALL have no effect.

Reset
REQ-028 While rst=0, SHALL hold state IDLE, counter 0, hi=0, lo=0, busy=0, done=0 and stall_req=0 (start ignored).
REQ-029 Reset asserted mid-operation SHALL abort it immediately with no done pulse; the first start after release behaves as from power-up.

Structure
REQ-030 Package mdu_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state typedef.
REQ-031 Sub-module mdu_abs (two's-complement conditional negate, WIDTH-parametrised) SHALL be instantiated for operand magnitudes and result correction; everything else stays in mul_div_unit.

Verification (WIDTH=32)
REQ-032 Start MULT a=0xFFFFFFFF b=3 -> done at edge t0+33, hi=0xFFFFFFFF, lo=0xFFFFFFFD; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFD.
REQ-033 DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=0x00000007; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Flush at cycle 10 of CALC with hi/lo=0x11/0x22 -> IDLE next edge, no done, hi/lo unchanged, busy=0.
REQ-035 Start accepted in DONE (back-to-back MULTU 2*3 then 4*5) -> two done pulses 34 cycles apart, final lo=20; a lo_we during CALC is ignored, and a lo_we in IDLE makes lo equal wdata next cycle.
REQ-036 rst low mid-CALC -> all outputs 0 asynchronously; after release, start MULTU 5*5 -> lo=25 at normal latency.
